adder_operand_pairer: RTL and testbench

- Upstream feeder for the variable-input sequential adder.
- Collects operands from two independent streams, A and B, and buffers each in its own small FIFO.
- Presents them as a paired 2-operand bus, with per-operand valid bits, in the exact format the adder consumes.
- A lone operand is forwarded unpaired after a programmable timeout or on flush, so the adder can pass it through.

---
 rtl/adder_operand_pairer_pkg.sv | 17 +
 rtl/adder_operand_pairer_sync_fifo_simple.sv | 55 +++++
 rtl/adder_operand_pairer.sv | 117 +++++++++++
 tb/tb_adder_operand_pairer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_operand_pairer_pkg.sv
// Shared constants helper for the adder operand pairer slice.
package adder_operand_pairer_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 1) ? value - 1 : 0;
    while (rem != 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_operand_pairer_sync_fifo_simple.sv
// Single-clock FIFO with combinational head read and count-based full/empty.
module sync_fifo_simple
  import adder_operand_pairer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W = clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_operand_pairer.sv
// Buffers operand streams A and B and emits them as a paired bus; a lone
// head is emitted unpaired on flush or after TIMEOUT waiting cycles.
module adder_operand_pairer
  import adder_operand_pairer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_valid_a,
  input  logic [DATA_WIDTH-1:0]   i_data_a,
  output logic                    o_ready_a,
  input  logic                    i_valid_b,
  input  logic [DATA_WIDTH-1:0]   i_data_b,
  output logic                    o_ready_b,
  input  logic                    i_flush,
  output logic [1:0]              o_valid,
  output logic [2*DATA_WIDTH-1:0] o_data_bus
);

  localparam int unsigned WAIT_W    = clog2(TIMEOUT) + 1;
  localparam int unsigned WAIT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam bit          TMO_EN    = (TIMEOUT != 0);

  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;
  logic                  full_a, full_b;
  logic                  empty_a, empty_b;
  logic                  push_a, push_b;
  logic                  pop_a, pop_b;
  logic                  pair, emit_a, emit_b, timed_out;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WAIT_W-1:0]     wait_next;

  assign o_ready_a = !full_a;
  assign o_ready_b = !full_b;
  assign push_a    = i_en && i_valid_a && !full_a;
  assign push_b    = i_en && i_valid_b && !full_b;

  sync_fifo_simple #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_a),
    .pop   (pop_a),
    .din   (i_data_a),
    .dout  (head_a),
    .full  (full_a),
    .empty (empty_a)
  );

  sync_fifo_simple #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_b),
    .pop   (pop_b),
    .din   (i_data_b),
    .dout  (head_b),
    .full  (full_b),
    .empty (empty_b)
  );

  // Emit decision from current occupancy; pairing always wins over a lone emit.
  always_comb begin
    pair      = 1'b0;
    emit_a    = 1'b0;
    emit_b    = 1'b0;
    timed_out = 1'b0;
    wait_next = '0;
    pop_a     = 1'b0;
    pop_b     = 1'b0;

    timed_out = TMO_EN && (wait_cnt == WAIT_W'(WAIT_LAST));
    pair      = !empty_a && !empty_b;
    emit_a    = !empty_a && empty_b && (i_flush || timed_out);
    emit_b    = empty_a && !empty_b && (i_flush || timed_out);
    pop_a     = i_en && (pair || emit_a);
    pop_b     = i_en && (pair || emit_b);

    if ((empty_a != empty_b) && !emit_a && !emit_b) begin
      wait_next = wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      o_valid    <= 2'b00;
      o_data_bus <= '0;
    end else if (i_en) begin
      wait_cnt <= wait_next;
      if (pair) begin
        o_valid    <= 2'b11;
        o_data_bus <= {head_a, head_b};
      end else if (emit_a) begin
        o_valid    <= 2'b10;
        o_data_bus <= {head_a, DATA_WIDTH'(0)};
      end else if (emit_b) begin
        o_valid    <= 2'b01;
        o_data_bus <= {DATA_WIDTH'(0), head_b};
      end else begin
        o_valid <= 2'b00;
      end
    end else begin
      o_valid <= 2'b00;
    end
  end

endmodule

// File: tb/tb_adder_operand_pairer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_adder_operand_pairer;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, va, vb, flush;
  logic [DW-1:0] da, db;
  logic [1:0]    valid;
  logic [2*DW-1:0] bus;
  logic          ra, rb;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int            wcnt;
  logic [1:0]    ev;
  logic [2*DW-1:0] ed;

  adder_operand_pairer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_valid_a  (va),
    .i_data_a   (da),
    .o_ready_a  (ra),
    .i_valid_b  (vb),
    .i_data_b   (db),
    .o_ready_b  (rb),
    .i_flush    (flush),
    .o_valid    (valid),
    .o_data_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    en = 1'b1; va = 1'b0; vb = 1'b0; flush = 1'b0; da = '0; db = '0;
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete(); wcnt = 0; ev = 2'b00; ed = '0;
  endtask

  // Applies one enabled-edge worth of pairing rules to the queues.
  task automatic model_step();
    int sa, sb;
    logic [DW-1:0] ha, hb;
    sa = qa.size(); sb = qb.size();
    if (!en) begin
      ev = 2'b00;
      return;
    end
    if (sa > 0 && sb > 0) begin
      ha = qa.pop_front(); hb = qb.pop_front();
      ev = 2'b11; ed = {ha, hb}; wcnt = 0;
    end else if (sa > 0 && sb == 0 && (flush || (TMO != 0 && wcnt == TMO - 1))) begin
      ha = qa.pop_front();
      ev = 2'b10; ed = {ha, 4'h0}; wcnt = 0;
    end else if (sb > 0 && sa == 0 && (flush || (TMO != 0 && wcnt == TMO - 1))) begin
      hb = qb.pop_front();
      ev = 2'b01; ed = {4'h0, hb}; wcnt = 0;
    end else begin
      ev = 2'b00;
      wcnt = (sa == 0 && sb == 0) ? 0 : wcnt + 1;
    end
    if (va && sa < DEPTH) qa.push_back(da);
    if (vb && sb < DEPTH) qb.push_back(db);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom); va = 1'($urandom); vb = 1'($urandom); flush = 1'($urandom);
      da = DW'($urandom); db = DW'($urandom);
      @(posedge clk); #1;
      total++;
      if (valid !== 2'b00 || bus !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold valid=%b bus=%h expected 00/00", valid, bus);
      end
    end
    idle();
    model_reset();
    rst_n = 1'b1;
    #1;
    total++;
    if (ra !== 1'b1 || rb !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready ready_a=%b ready_b=%b expected 1/1", ra, rb);
    end
  endtask

  task automatic test_same_edge_pair();
    idle();
    va = 1'b1; da = 4'hF; vb = 1'b1; db = 4'h0;
    tick();
    idle();
    total++;
    if (valid !== 2'b00) begin
      bad++; $display("FAIL pair_latency valid=%b expected 00", valid);
    end
    tick();
    total++;
    if (valid !== 2'b11 || bus !== 8'hF0) begin
      bad++; $display("FAIL pair_out valid=%b bus=%h expected 11/f0", valid, bus);
    end
    tick();
    total++;
    if (valid !== 2'b00 || bus !== 8'hF0) begin
      bad++; $display("FAIL pair_once valid=%b bus=%h expected 00/f0", valid, bus);
    end
  endtask

  task automatic test_timeout();
    idle();
    va = 1'b1; da = 4'h3;
    tick();
    idle();
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (valid !== 2'b00) begin
        bad++; $display("FAIL timeout_early edge=%0d valid=%b expected 00", k, valid);
      end
    end
    tick();
    total++;
    if (valid !== 2'b10 || bus !== 8'h30 || ra !== 1'b1) begin
      bad++; $display("FAIL timeout_emit valid=%b bus=%h ready_a=%b expected 10/30/1", valid, bus, ra);
    end
    tick();
    total++;
    if (valid !== 2'b00 || qa.size() != 0) begin
      bad++; $display("FAIL timeout_drained valid=%b expected 00", valid);
    end
  endtask

  task automatic test_full_flush();
    idle();
    for (int i = 1; i <= 4; i++) begin
      vb = 1'b1; db = DW'(i);
      tick();
      total++;
      if (rb !== (i < 4 ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL full_ready push=%0d ready_b=%b expected %b", i, rb, (i < 4));
      end
    end
    idle();
    vb = 1'b1; db = 4'h9;
    flush = 1'b1;
    tick();
    idle();
    total++;
    if (valid !== 2'b01 || bus !== 8'h01 || rb !== 1'b1) begin
      bad++; $display("FAIL flush_emit valid=%b bus=%h ready_b=%b expected 01/01/1", valid, bus, rb);
    end
    va = 1'b1; da = 4'hE;
    tick();
    idle();
    tick();
    total++;
    if (valid !== 2'b11 || bus !== 8'hE2) begin
      bad++; $display("FAIL late_partner valid=%b bus=%h expected 11/e2", valid, bus);
    end
    for (int i = 3; i <= 4; i++) begin
      flush = 1'b1;
      tick();
      total++;
      if (valid !== 2'b01 || bus !== {4'h0, DW'(i)}) begin
        bad++; $display("FAIL flush_drain valid=%b bus=%h expected 01/0%0d", valid, bus, i);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_enable_freeze();
    idle();
    va = 1'b1; da = 4'h7;
    tick();
    idle();
    for (int k = 0; k < 5; k++) tick();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (valid !== 2'b00 || bus !== 8'h04) begin
        bad++; $display("FAIL freeze valid=%b bus=%h expected 00/04", valid, bus);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++;
      if (valid !== 2'b00) begin
        bad++; $display("FAIL resume_early edge=%0d valid=%b expected 00", k, valid);
      end
    end
    tick();
    total++;
    if (valid !== 2'b10 || bus !== 8'h70) begin
      bad++; $display("FAIL resume_emit valid=%b bus=%h expected 10/70", valid, bus);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(9) != 0);
      va    = 1'($urandom);
      vb    = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      da    = DW'($urandom);
      db    = DW'($urandom);
      tick();
      total++;
      if (valid !== ev || bus !== ed || ra !== (qa.size() < DEPTH) || rb !== (qb.size() < DEPTH)) begin
        bad++;
        $display("FAIL random cyc=%0d valid=%b bus=%h ra=%b rb=%b expected %b/%h/%b/%b",
                 i, valid, bus, ra, rb, ev, ed, (qa.size() < DEPTH), (qb.size() < DEPTH));
      end
    end
    idle();
  endtask

  task automatic test_reset_midstream();
    idle();
    for (int i = 0; i < 3; i++) begin
      vb = 1'b1; db = DW'(4'hA + i);
      tick();
    end
    idle();
    va = 1'b1; da = 4'h5;
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (valid !== 2'b00 || bus !== 8'h00 || ra !== 1'b1 || rb !== 1'b1) begin
      bad++; $display("FAIL midreset valid=%b bus=%h ra=%b rb=%b expected 00/00/1/1", valid, bus, ra, rb);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (valid !== 2'b00) begin
        bad++; $display("FAIL stale_after_reset edge=%0d valid=%b expected 00", k, valid);
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_same_edge_pair();
    test_timeout();
    test_full_flush();
    test_enable_freeze();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
